// File: rtl/pipe_stage_regs_pkg.sv
// Shared Y86 pipeline constants and packed record layouts for the F/D/E/M/W registers.
package pipe_stage_regs_pkg;

   localparam logic [7:0] INOP     = 8'h01;
   localparam logic [7:0] RNONE    = 8'h0F;
   localparam logic [7:0] SAOK     = 8'h01;
   localparam logic [7:0] SBUB     = 8'h00;
   localparam logic [2:0] CC_RESET = 3'b100;

   typedef struct packed {
      logic [7:0]  stat;
      logic [7:0]  icode;
      logic [7:0]  ifun;
      logic [7:0]  rA;
      logic [7:0]  rB;
      logic [31:0] valC;
      logic [31:0] valP;
   } d_reg_t;

   typedef struct packed {
      logic [7:0]  stat;
      logic [7:0]  icode;
      logic [7:0]  ifun;
      logic [7:0]  dstE;
      logic [7:0]  dstM;
      logic [7:0]  srcA;
      logic [7:0]  srcB;
      logic [31:0] valC;
      logic [31:0] valA;
      logic [31:0] valB;
   } e_reg_t;

   typedef struct packed {
      logic [7:0]  stat;
      logic [7:0]  icode;
      logic [7:0]  dstE;
      logic [7:0]  dstM;
      logic        Cnd;
      logic [31:0] valE;
      logic [31:0] valA;
   } m_reg_t;

   typedef struct packed {
      logic [7:0]  stat;
      logic [7:0]  icode;
      logic [7:0]  dstE;
      logic [7:0]  dstM;
      logic [31:0] valE;
      logic [31:0] valM;
   } w_reg_t;

   localparam d_reg_t D_BUBBLE = '{stat: SBUB, icode: INOP, ifun: 8'h00, rA: RNONE, rB: RNONE,
                                   valC: 32'h0, valP: 32'h0};
   localparam e_reg_t E_BUBBLE = '{stat: SBUB, icode: INOP, ifun: 8'h00, dstE: RNONE, dstM: RNONE,
                                   srcA: RNONE, srcB: RNONE, valC: 32'h0, valA: 32'h0, valB: 32'h0};
   localparam m_reg_t M_BUBBLE = '{stat: SBUB, icode: INOP, dstE: RNONE, dstM: RNONE, Cnd: 1'b0,
                                   valE: 32'h0, valA: 32'h0};
   localparam w_reg_t W_BUBBLE = '{stat: SBUB, icode: INOP, dstE: RNONE, dstM: RNONE,
                                   valE: 32'h0, valM: 32'h0};

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register: reset > stall > bubble > load. Reset loads the bubble value.
module pipe_stage_reg #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             bubble_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // NOTE: non-blocking so every stage samples the pre-edge value of its neighbour.
   always_ff @(posedge clk) begin
      if (rst)
         q_o <= BUBBLE_VAL;
      else if (!stall_i)
         q_o <= bubble_i ? BUBBLE_VAL : d_i;
   end

endmodule

// File: rtl/pipe_stage_regs.sv
// Y86 F/D/E/M/W pipeline register bank with condition codes and a sticky stall/bubble conflict flag.
module pipe_stage_regs
   import pipe_stage_regs_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        F_stall_i,
   input  logic        D_stall_i,
   input  logic        D_bubble_i,
   input  logic        E_bubble_i,
   input  logic        M_bubble_i,
   input  logic        W_stall_i,
   input  logic        set_cc_i,
   input  logic [31:0] f_predPC_i,
   output logic [31:0] F_predPC_o,
   input  logic [7:0]  f_stat_i, f_icode_i, f_ifun_i, f_rA_i, f_rB_i,
   input  logic [31:0] f_valC_i, f_valP_i,
   output logic [7:0]  D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o,
   output logic [31:0] D_valC_o, D_valP_o,
   input  logic [7:0]  d_stat_i, d_icode_i, d_ifun_i, d_dstE_i, d_dstM_i, d_srcA_i, d_srcB_i,
   input  logic [31:0] d_valC_i, d_valA_i, d_valB_i,
   output logic [7:0]  E_stat_o, E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o,
   output logic [31:0] E_valC_o, E_valA_o, E_valB_o,
   input  logic [7:0]  e_stat_i, e_icode_i, e_dstE_i, e_dstM_i,
   input  logic        e_Cnd_i,
   input  logic [31:0] e_valE_i, e_valA_i,
   input  logic [2:0]  e_cc_i,
   output logic [7:0]  M_stat_o, M_icode_o, M_dstE_o, M_dstM_o,
   output logic        M_Cnd_o,
   output logic [31:0] M_valE_o, M_valA_o,
   input  logic [7:0]  m_stat_i, m_icode_i, m_dstE_i, m_dstM_i,
   input  logic [31:0] m_valE_i, m_valM_i,
   output logic [7:0]  W_stat_o, W_icode_o, W_dstE_o, W_dstM_o,
   output logic [31:0] W_valE_o, W_valM_o,
   output logic [2:0]  cc_o,
   output logic        ctrl_err_o
);

   d_reg_t d_next, d_q;
   e_reg_t e_next, e_q;
   m_reg_t m_next, m_q;
   w_reg_t w_next, w_q;

   assign d_next = '{f_stat_i, f_icode_i, f_ifun_i, f_rA_i, f_rB_i, f_valC_i, f_valP_i};
   assign e_next = '{d_stat_i, d_icode_i, d_ifun_i, d_dstE_i, d_dstM_i, d_srcA_i, d_srcB_i,
                     d_valC_i, d_valA_i, d_valB_i};
   assign m_next = '{e_stat_i, e_icode_i, e_dstE_i, e_dstM_i, e_Cnd_i, e_valE_i, e_valA_i};
   assign w_next = '{m_stat_i, m_icode_i, m_dstE_i, m_dstM_i, m_valE_i, m_valM_i};

   pipe_stage_reg #(.WIDTH(32), .BUBBLE_VAL(RESET_PC)) u_f (
      .clk(clk), .rst(rst), .stall_i(F_stall_i), .bubble_i(1'b0),
      .d_i(f_predPC_i), .q_o(F_predPC_o));

   // Stall outranks bubble inside the register, so a D conflict holds D.
   pipe_stage_reg #(.WIDTH($bits(d_reg_t)), .BUBBLE_VAL(D_BUBBLE)) u_d (
      .clk(clk), .rst(rst), .stall_i(D_stall_i), .bubble_i(D_bubble_i),
      .d_i(d_next), .q_o(d_q));

   pipe_stage_reg #(.WIDTH($bits(e_reg_t)), .BUBBLE_VAL(E_BUBBLE)) u_e (
      .clk(clk), .rst(rst), .stall_i(1'b0), .bubble_i(E_bubble_i),
      .d_i(e_next), .q_o(e_q));

   pipe_stage_reg #(.WIDTH($bits(m_reg_t)), .BUBBLE_VAL(M_BUBBLE)) u_m (
      .clk(clk), .rst(rst), .stall_i(1'b0), .bubble_i(M_bubble_i),
      .d_i(m_next), .q_o(m_q));

   pipe_stage_reg #(.WIDTH($bits(w_reg_t)), .BUBBLE_VAL(W_BUBBLE)) u_w (
      .clk(clk), .rst(rst), .stall_i(W_stall_i), .bubble_i(1'b0),
      .d_i(w_next), .q_o(w_q));

   assign {D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o} = d_q;
   assign {E_stat_o, E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o,
           E_valC_o, E_valA_o, E_valB_o} = e_q;
   assign {M_stat_o, M_icode_o, M_dstE_o, M_dstM_o, M_Cnd_o, M_valE_o, M_valA_o} = m_q;
   assign {W_stat_o, W_icode_o, W_dstE_o, W_dstM_o, W_valE_o, W_valM_o} = w_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cc_o       <= CC_RESET;
         ctrl_err_o <= 1'b0;
      end else begin
         if (set_cc_i)
            cc_o <= e_cc_i;
         if (D_stall_i && D_bubble_i)
            ctrl_err_o <= 1'b1;
      end
   end

endmodule
